// File: rtl/sec_timer_sched.sv
// Multi-channel one-second countdown scheduler with a round-robin arm arbiter.
// Optional turbo request output is built only when SEC_TIMER_TURBO_EN is defined.
module sec_timer_sched #(
  parameter int unsigned NUM_CH    = 4,
  parameter int unsigned CNT_W     = 8,
  parameter int unsigned TURBO_THR = 3
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       one_sec,
  input  logic                       pause,
  input  logic [NUM_CH-1:0]          load_req,
  input  logic [NUM_CH*CNT_W-1:0]    load_val,
  input  logic [NUM_CH-1:0]          cancel,
  input  logic [$clog2(NUM_CH)-1:0]  rd_sel,
  output logic [NUM_CH-1:0]          load_gnt,
  output logic [NUM_CH-1:0]          active,
  output logic [NUM_CH-1:0]          expired,
  output logic [CNT_W-1:0]           remaining,
  output logic                       turbo
);

  localparam int unsigned PtrW = $clog2(NUM_CH);

  logic [PtrW-1:0]                ptr_q, ptr_d;
  logic [NUM_CH-1:0]              gnt_q, gnt_d;
  logic [NUM_CH-1:0]              active_q, active_d;
  logic [NUM_CH-1:0]              expired_q, expired_d;
  logic [NUM_CH-1:0][CNT_W-1:0]   count_q, count_d;
  logic [NUM_CH-1:0]              eligible;
  logic                           tick;

  assign tick = one_sec & ~pause;

  // Walk offsets from the far end so the nearest eligible channel to ptr wins.
  always_comb begin
    int idx;
    eligible = load_req & ~gnt_q & ~cancel;
    gnt_d    = '0;
    ptr_d    = ptr_q;
    idx      = 0;
    for (int k = int'(NUM_CH) - 1; k >= 0; k--) begin
      idx = (int'(ptr_q) + k) % int'(NUM_CH);
      if (eligible[idx]) begin
        gnt_d      = '0;
        gnt_d[idx] = 1'b1;
        ptr_d      = PtrW'((idx + 1) % int'(NUM_CH));
      end
    end
  end

  always_comb begin
    active_d  = active_q;
    count_d   = count_q;
    expired_d = '0;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      if (cancel[i]) begin
        active_d[i] = 1'b0;
        count_d[i]  = '0;
      end else if (gnt_d[i]) begin
        active_d[i] = 1'b1;
        count_d[i]  = load_val[i*CNT_W +: CNT_W];
      end else if (active_q[i]) begin
        // An armed count of zero only comes from a zero load; it expires without a tick.
        if (count_q[i] == '0) begin
          active_d[i]  = 1'b0;
          expired_d[i] = 1'b1;
        end else if (tick) begin
          count_d[i] = count_q[i] - 1'b1;
          if (count_q[i] == CNT_W'(1)) begin
            active_d[i]  = 1'b0;
            expired_d[i] = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q     <= '0;
      gnt_q     <= '0;
      active_q  <= '0;
      expired_q <= '0;
      count_q   <= '0;
    end else begin
      ptr_q     <= ptr_d;
      gnt_q     <= gnt_d;
      active_q  <= active_d;
      expired_q <= expired_d;
      count_q   <= count_d;
    end
  end

  assign load_gnt  = gnt_q;
  assign active    = active_q;
  assign expired   = expired_q;
  assign remaining = count_q[rd_sel];

`ifdef SEC_TIMER_TURBO_EN
  localparam logic [CNT_W-1:0] ThrCnt = CNT_W'(TURBO_THR);

  logic turbo_q, turbo_d;

  always_comb begin
    turbo_d = 1'b0;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      if (active_q[i] && (count_q[i] <= ThrCnt)) begin
        turbo_d = 1'b1;
      end
    end
    if (pause) begin
      turbo_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      turbo_q <= 1'b0;
    end else begin
      turbo_q <= turbo_d;
    end
  end

  assign turbo = turbo_q;
`else
  logic [31:0] unused_turbo_thr;
  assign unused_turbo_thr = TURBO_THR;
  assign turbo = 1'b0;
`endif

endmodule

// File: tb/tb_sec_timer_sched.sv
// Self-checking bench for sec_timer_sched: directed vector table, hand sequences for
// multi-cycle corners, and a randomized run against a behavioural countdown model.
module tb_sec_timer_sched;

  localparam int NCH = 4;
  localparam int CW  = 8;

  logic        clk = 1'b0;
  logic        reset, one_sec, pause;
  logic [3:0]  load_req, cancel, load_gnt, active, expired;
  logic [31:0] load_val;
  logic [1:0]  rd_sel;
  logic [7:0]  remaining;
  logic        turbo;

  always #5 clk = ~clk;

  sec_timer_sched #(
    .NUM_CH   (NCH),
    .CNT_W    (CW),
    .TURBO_THR(3)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .one_sec  (one_sec),
    .pause    (pause),
    .load_req (load_req),
    .load_val (load_val),
    .cancel   (cancel),
    .rd_sel   (rd_sel),
    .load_gnt (load_gnt),
    .active   (active),
    .expired  (expired),
    .remaining(remaining),
    .turbo    (turbo)
  );

  int checks = 0;
  int errors = 0;

  // Behavioural model state: plain integers per channel.
  int m_cnt[NCH];
  bit m_act[NCH];
  bit m_gnt[NCH];
  bit m_exp[NCH];
  int m_ptr;
  bit m_turbo;

  typedef struct {
    logic        rst, tick, pause;
    logic [3:0]  req;
    logic [31:0] val;
    logic [3:0]  cancel;
    logic [1:0]  sel;
    logic [3:0]  e_gnt, e_act, e_exp;
    logic [7:0]  e_rem;
  } vec_t;

  vec_t vecs[20];

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  task automatic model_edge(bit r, bit t, bit p, logic [3:0] rq, logic [31:0] v,
                            logic [3:0] c);
    int g;
    if (r) begin
      for (int i = 0; i < NCH; i++) begin
        m_cnt[i] = 0; m_act[i] = 0; m_gnt[i] = 0; m_exp[i] = 0;
      end
      m_ptr   = 0;
      m_turbo = 0;
      return;
    end
`ifdef SEC_TIMER_TURBO_EN
    m_turbo = 0;
    for (int i = 0; i < NCH; i++) if (m_act[i] && m_cnt[i] <= 3) m_turbo = 1;
    if (p) m_turbo = 0;
`else
    m_turbo = 0;
`endif
    g = -1;
    for (int k = 0; k < NCH; k++) begin
      int ch;
      ch = (m_ptr + k) % NCH;
      if (g < 0 && rq[ch] && !m_gnt[ch] && !c[ch]) g = ch;
    end
    if (g >= 0) m_ptr = (g + 1) % NCH;
    for (int i = 0; i < NCH; i++) begin
      m_gnt[i] = (i == g);
      m_exp[i] = 0;
      if (c[i]) begin
        m_cnt[i] = 0; m_act[i] = 0;
      end else if (i == g) begin
        m_cnt[i] = int'(v[i*CW +: CW]); m_act[i] = 1;
      end else if (m_act[i]) begin
        if (m_cnt[i] == 0) begin
          m_act[i] = 0; m_exp[i] = 1;
        end else if (t && !p) begin
          m_cnt[i] = m_cnt[i] - 1;
          if (m_cnt[i] == 0) begin
            m_act[i] = 0; m_exp[i] = 1;
          end
        end
      end
    end
  endtask

  task automatic step(bit r, bit t, bit p, logic [3:0] rq, logic [31:0] v, logic [3:0] c,
                      logic [1:0] s);
    logic [3:0] eg, ea, ee;
    reset = r; one_sec = t; pause = p; load_req = rq; load_val = v; cancel = c; rd_sel = s;
    @(posedge clk);
    model_edge(r, t, p, rq, v, c);
    #1;
    for (int i = 0; i < NCH; i++) begin
      eg[i] = m_gnt[i]; ea[i] = m_act[i]; ee[i] = m_exp[i];
    end
    check("model_gnt", 32'(load_gnt), 32'(eg));
    check("model_active", 32'(active), 32'(ea));
    check("model_expired", 32'(expired), 32'(ee));
    check("model_remaining", 32'(remaining), 32'(m_cnt[s]));
    check("model_turbo", 32'(turbo), 32'(m_turbo));
  endtask

  initial begin
    logic [3:0]  order[5];
    logic [31:0] rv;
    logic [3:0]  rq, rc;
    bit          exp_turbo[6];

    reset = 1'b1; one_sec = 1'b0; pause = 1'b0; load_req = '0; load_val = '0;
    cancel = '0; rd_sel = '0;

    //           rst  tick pause req   val           cancel sel   gnt   act   exp   rem
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 4'h0, 32'h0000_0000, 4'h0, 2'd0, 4'h0, 4'h0, 4'h0, 8'd0};
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 4'h1, 32'h0000_0005, 4'h0, 2'd0, 4'h1, 4'h1, 4'h0, 8'd5};
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 4'h0, 32'h0000_0005, 4'h0, 2'd0, 4'h0, 4'h1, 4'h0, 8'd4};
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 4'h0, 32'h0000_0000, 4'h0, 2'd0, 4'h0, 4'h1, 4'h0, 8'd3};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 4'h0, 32'h0000_0000, 4'h0, 2'd0, 4'h0, 4'h1, 4'h0, 8'd3};
    vecs[5]  = '{1'b0, 1'b1, 1'b0, 4'h0, 32'h0000_0000, 4'h0, 2'd0, 4'h0, 4'h1, 4'h0, 8'd2};
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 4'h0, 32'h0000_0000, 4'h0, 2'd0, 4'h0, 4'h1, 4'h0, 8'd1};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 4'h0, 32'h0000_0000, 4'h0, 2'd0, 4'h0, 4'h0, 4'h1, 8'd0};
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 4'h0, 32'h0000_0000, 4'h0, 2'd0, 4'h0, 4'h0, 4'h0, 8'd0};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 4'h2, 32'h0000_0000, 4'h0, 2'd1, 4'h2, 4'h2, 4'h0, 8'd0};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 4'h0, 32'h0000_0000, 4'h0, 2'd1, 4'h0, 4'h0, 4'h2, 8'd0};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 4'h0, 32'h0000_0000, 4'h0, 2'd1, 4'h0, 4'h0, 4'h0, 8'd0};
    vecs[12] = '{1'b0, 1'b0, 1'b0, 4'h4, 32'h0009_0000, 4'h4, 2'd2, 4'h0, 4'h0, 4'h0, 8'd0};
    vecs[13] = '{1'b0, 1'b0, 1'b0, 4'h4, 32'h0009_0000, 4'h0, 2'd2, 4'h4, 4'h4, 4'h0, 8'd9};
    vecs[14] = '{1'b0, 1'b1, 1'b1, 4'h0, 32'h0000_0000, 4'h0, 2'd2, 4'h0, 4'h4, 4'h0, 8'd9};
    vecs[15] = '{1'b0, 1'b1, 1'b0, 4'h0, 32'h0000_0000, 4'h0, 2'd2, 4'h0, 4'h4, 4'h0, 8'd8};
    vecs[16] = '{1'b0, 1'b1, 1'b0, 4'h4, 32'h0002_0000, 4'h0, 2'd2, 4'h4, 4'h4, 4'h0, 8'd2};
    vecs[17] = '{1'b0, 1'b1, 1'b0, 4'h0, 32'h0000_0000, 4'h0, 2'd2, 4'h0, 4'h4, 4'h0, 8'd1};
    vecs[18] = '{1'b0, 1'b1, 1'b0, 4'h0, 32'h0000_0000, 4'h4, 2'd2, 4'h0, 4'h0, 4'h0, 8'd0};
    vecs[19] = '{1'b0, 1'b0, 1'b0, 4'h0, 32'h0000_0000, 4'h0, 2'd2, 4'h0, 4'h0, 4'h0, 8'd0};

    #2;
    for (int i = 0; i < 20; i++) begin
      step(vecs[i].rst, vecs[i].tick, vecs[i].pause, vecs[i].req, vecs[i].val,
           vecs[i].cancel, vecs[i].sel);
      check($sformatf("vec%0d_gnt", i), 32'(load_gnt), 32'(vecs[i].e_gnt));
      check($sformatf("vec%0d_active", i), 32'(active), 32'(vecs[i].e_act));
      check($sformatf("vec%0d_expired", i), 32'(expired), 32'(vecs[i].e_exp));
      check($sformatf("vec%0d_remaining", i), 32'(remaining), 32'(vecs[i].e_rem));
    end

    // Slow ticks: one every 10 cycles on channel 0 loaded with 5.
    step(1, 0, 0, 4'h0, 32'h0, 4'h0, 2'd0);
    step(0, 0, 0, 4'h1, 32'h0000_0005, 4'h0, 2'd0);
    check("slow_gnt", 32'(load_gnt), 32'h1);
    check("slow_load", 32'(remaining), 32'd5);
    for (int n = 1; n <= 5; n++) begin
      for (int w = 0; w < 9; w++) step(0, 0, 0, 4'h0, 32'h0, 4'h0, 2'd0);
      check($sformatf("slow_hold%0d", n), 32'(remaining), 32'(6 - n));
      step(0, 1, 0, 4'h0, 32'h0, 4'h0, 2'd0);
      check($sformatf("slow_rem%0d", n), 32'(remaining), 32'(5 - n));
      check($sformatf("slow_exp%0d", n), 32'(expired[0]), 32'(n == 5));
    end

    // All requests held: strict rotation, no back-to-back repeat.
    order = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1};
    step(1, 0, 0, 4'h0, 32'h0, 4'h0, 2'd0);
    for (int k = 0; k < 5; k++) begin
      step(0, 0, 0, 4'hF, 32'h281E_140A, 4'h0, 2'(k % 4));
      check($sformatf("rr_gnt%0d", k), 32'(load_gnt), 32'(order[k]));
    end

    // Cancel wins over a tick that would have expired channel 1.
    step(1, 0, 0, 4'h0, 32'h0, 4'h0, 2'd1);
    step(0, 0, 0, 4'h2, 32'h0000_0200, 4'h0, 2'd1);
    step(0, 1, 0, 4'h0, 32'h0, 4'h0, 2'd1);
    check("cancel_pre", 32'(remaining), 32'd1);
    step(0, 1, 0, 4'h0, 32'h0, 4'h2, 2'd1);
    check("cancel_active", 32'(active[1]), 32'd0);
    check("cancel_noexp", 32'(expired[1]), 32'd0);
    step(0, 0, 0, 4'h0, 32'h0, 4'h0, 2'd1);
    check("cancel_noexp_late", 32'(expired[1]), 32'd0);

    // Paused ticks on channel 2 are dropped.
    step(1, 0, 0, 4'h0, 32'h0, 4'h0, 2'd2);
    step(0, 0, 0, 4'h4, 32'h0004_0000, 4'h0, 2'd2);
    for (int k = 0; k < 3; k++) begin
      step(0, 1, 1, 4'h0, 32'h0, 4'h0, 2'd2);
      check($sformatf("pause_hold%0d", k), 32'(remaining), 32'd4);
    end
    step(0, 1, 0, 4'h0, 32'h0, 4'h0, 2'd2);
    check("pause_resume", 32'(remaining), 32'd3);

    // Turbo follows the count of channel 0 with one cycle of register delay.
`ifdef SEC_TIMER_TURBO_EN
    exp_turbo = '{0, 0, 1, 1, 1, 0};
`else
    exp_turbo = '{0, 0, 0, 0, 0, 0};
`endif
    step(1, 0, 0, 4'h0, 32'h0, 4'h0, 2'd0);
    step(0, 0, 0, 4'h1, 32'h0000_0005, 4'h0, 2'd0);
    check("turbo_load", 32'(turbo), 32'd0);
    for (int k = 0; k < 6; k++) begin
      step(0, (k < 5), 0, 4'h0, 32'h0, 4'h0, 2'd0);
      check($sformatf("turbo%0d", k), 32'(turbo), 32'(exp_turbo[k]));
    end

    // Randomized traffic against the model.
    step(1, 0, 0, 4'h0, 32'h0, 4'h0, 2'd0);
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < NCH; i++) rv[i*CW +: CW] = 8'($urandom_range(0, 7));
      rq = 4'($urandom) & 4'($urandom);
      rc = ($urandom_range(0, 7) == 0) ? 4'(1 << $urandom_range(0, 3)) : 4'h0;
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 7) == 0), rq, rv, rc, 2'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sec_timer_sched.md
SEC_TIMER_SCHED -- requirements
Module: sec_timer_sched

Interface
REQ-001 The block SHALL have parameter NUM_CH, default 4, giving the number of countdown channels (2..8).
REQ-002 The block SHALL have parameter CNT_W, default 8, giving the countdown width in seconds.
REQ-003 The block SHALL have parameter TURBO_THR, default 3, giving the remaining-seconds threshold for the turbo request.
REQ-004 The block SHALL have port clk, input, 1 bit: the single system clock, rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port one_sec, input, 1 bit: one-cycle tick pulse from the one-second counter.
REQ-007 The block SHALL have port pause, input, 1 bit: while high, ticks are ignored by every channel.
REQ-008 The block SHALL have port load_req, input, NUM_CH bits: per-channel arm request, held until granted.
REQ-009 The block SHALL have port load_val, input, NUM_CH*CNT_W bits: per-channel start value, where channel i is bits [i*CNT_W +: CNT_W].
REQ-010 The block SHALL have port cancel, input, NUM_CH bits: per-channel abort.
REQ-011 The block SHALL have port rd_sel, input, $clog2(NUM_CH) bits: selects the channel shown on remaining.
REQ-012 The block SHALL have port load_gnt, output, NUM_CH bits: one-cycle, one-hot grant.
REQ-013 The block SHALL have port active, output, NUM_CH bits: the channel is counting.
REQ-014 The block SHALL have port expired, output, NUM_CH bits: one-cycle pulse when a count reaches zero.
REQ-015 The block SHALL have port remaining, output, CNT_W bits: the count of channel rd_sel, combinational mux of registered counts.
REQ-016 The block SHALL have port turbo, output, 1 bit: registered; drives the turbo input of the one-second counter.

Function
REQ-017 The arbiter SHALL grant at most one channel per cycle, round-robin, starting the search at the channel after the last granted one.
REQ-018 A channel SHALL be ineligible in any cycle where its load_gnt is already high or its cancel is high.
REQ-019 On a decision in cycle N, load_gnt[i] SHALL be high in cycle N+1, and at that same edge count[i]=load_val[i] and active[i]=1.
REQ-020 A grant to a running channel SHALL reload its count (re-arm) without asserting expired.
REQ-021 On one_sec=1 with pause=0, every active channel not being loaded or cancelled that cycle SHALL decrement by 1.
REQ-022 A channel whose decrement takes count from 1 to 0 SHALL set active=0 and pulse expired for exactly one cycle at that edge.
REQ-023 A grant with load_val=0 SHALL pulse expired on the cycle after load_gnt, at which point active returns to 0.
REQ-024 cancel[i] SHALL clear active[i] and count[i] at the next edge, with no expired pulse; cancel SHALL win over a simultaneous tick or load.
REQ-025 A load on the same edge as a tick SHALL win, and the loaded value SHALL NOT be decremented on that edge.
REQ-026 Counts SHALL never wrap: an inactive channel SHALL hold 0, and ticks SHALL be ignored for it.
REQ-027 Ticks arriving while pause=1 SHALL be dropped, not queued.

Reset
REQ-028 While reset=1 at a clock edge: load_gnt, active, expired and turbo SHALL become 0, all counts SHALL become 0, and the round-robin pointer SHALL reset so channel 0 has highest priority.
REQ-029 Reset SHALL override every other input, including mid-count and mid-grant, and no expired pulse SHALL be produced by reset.

Configuration
REQ-030 When macro SEC_TIMER_TURBO_EN is defined, turbo SHALL be registered as 1 when pause=0 and at least one active channel has a count of TURBO_THR or less; otherwise it SHALL be 0.
REQ-031 When SEC_TIMER_TURBO_EN is undefined, turbo SHALL be constant 0 and no comparator logic SHALL be synthesised.

Verification
REQ-032 Reset, then load_req=0001 and val0=5, with a tick every 10 cycles -> load_gnt=0001 one cycle later, remaining 5,4,3,2,1, and expired[0] pulses on the fifth tick.
REQ-033 load_req=1111 held continuously -> grants occur in the order 0001, 0010, 0100, 1000, with no repeat grant while a request is held through its own grant.
REQ-034 Channel 1 at count 1, with cancel[1] and one_sec in the same cycle -> active[1]=0 and expired[1] stays 0.
REQ-035 Channel 2 running at count 4, with pause=1 across 3 ticks -> count stays 4; after pause=0, the next tick gives 3.
REQ-036 With SEC_TIMER_TURBO_EN defined, channel 0 loaded with 5 and ticked -> turbo rises the cycle after count reaches 3 and falls after expired; with the macro undefined, turbo stays 0 throughout.
